// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS core: one FSM sequences fetch/decode/exec/mem/wb over a shared ready-handshake
// bus. Define MIPS_MC_JUMP_EN to execute opcode 000010 as J; otherwise it is illegal and halts.
module mips_multicycle #(
  parameter int unsigned ADDR_W   = 16,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned REGOUT_W = 12
) (
  input  logic                clk,
  input  logic                rst,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  input  logic                mem_ready,
  input  logic [4:0]          dbg_sel,
  output logic [REGOUT_W-1:0] regout,
  output logic                retire,
  output logic                halted
);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
`ifdef MIPS_MC_JUMP_EN
  localparam logic [5:0] OpJ     = 6'h02;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       alu_q, alu_d;
  logic [31:0]       mdr_q, mdr_d;
  logic              retire_q, retire_d;
  logic [31:0]       regs_q [32];

  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [31:0]       rf_wdata;

  logic [5:0]        op, funct;
  logic [4:0]        rs, rt, rd, shamt;
  logic [15:0]       imm;
  logic              is_rtype, is_lw, is_sw, is_bne, funct_legal, op_legal;
  logic [31:0]       alu_res;
  logic [ADDR_W-1:0] eff_addr, br_target;

  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign shamt = ir_q[10:6];
  assign funct = ir_q[5:0];
  assign imm   = ir_q[15:0];

  assign is_rtype = (op == OpRtype);
  assign is_lw    = (op == OpLw);
  assign is_sw    = (op == OpSw);
  assign is_bne   = (op == OpBne);

  always_comb begin
    funct_legal = 1'b0;
    alu_res     = '0;
    case (funct)
      6'h20: begin funct_legal = 1'b1; alu_res = a_q + b_q;      end
      6'h22: begin funct_legal = 1'b1; alu_res = a_q - b_q;      end
      6'h24: begin funct_legal = 1'b1; alu_res = a_q & b_q;      end
      6'h25: begin funct_legal = 1'b1; alu_res = a_q | b_q;      end
      6'h00: begin funct_legal = 1'b1; alu_res = b_q << shamt;   end
      6'h02: begin funct_legal = 1'b1; alu_res = b_q >> shamt;   end
      default: ;
    endcase
  end

`ifdef MIPS_MC_JUMP_EN
  assign op_legal = (is_rtype && funct_legal) || is_lw || is_sw || (op == OpBeq) || is_bne ||
                    (op == OpJ);
`else
  assign op_legal = (is_rtype && funct_legal) || is_lw || is_sw || (op == OpBeq) || is_bne;
`endif

  // Word-aligned effective address and branch target, both wrapping in the ADDR_W space.
  assign eff_addr  = ADDR_W'(a_q + {{16{imm[15]}}, imm}) & ~ADDR_W'(3);
  assign br_target = pc_q + ADDR_W'({{14{imm[15]}}, imm, 2'b00});

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    retire_d = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    case (state_q)
      StFetch: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(4);
          state_d = StDecode;
        end
      end
      StDecode: begin
        a_d     = regs_q[rs];
        b_d     = regs_q[rt];
        state_d = op_legal ? StExec : StHalt;
      end
      StExec: begin
        if (is_rtype) begin
          alu_d   = alu_res;
          state_d = StWb;
        end else if (is_lw || is_sw) begin
          alu_d   = 32'(eff_addr);
          state_d = StMem;
        end else begin
          if (op == OpBeq || is_bne) begin
            if ((a_q == b_q) ^ is_bne) pc_d = br_target;
`ifdef MIPS_MC_JUMP_EN
          end else begin
            pc_d = ADDR_W'({4'(32'(pc_q) >> 28), ir_q[25:0], 2'b00});
`endif
          end
          retire_d = 1'b1;
          state_d  = StFetch;
        end
      end
      StMem: begin
        if (mem_ready) begin
          if (is_sw) begin
            retire_d = 1'b1;
            state_d  = StFetch;
          end else begin
            mdr_d   = mem_rdata;
            state_d = StWb;
          end
        end
      end
      StWb: begin
        rf_we    = 1'b1;
        rf_waddr = is_rtype ? rd : rt;
        rf_wdata = is_rtype ? alu_q : mdr_q;
        retire_d = 1'b1;
        state_d  = StFetch;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StHalt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StFetch;
      pc_q     <= ADDR_W'(RESET_PC);
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      alu_q    <= '0;
      mdr_q    <= '0;
      retire_q <= 1'b0;
      regs_q   <= '{default: '0};
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      alu_q    <= alu_d;
      mdr_q    <= mdr_d;
      retire_q <= retire_d;
      if (rf_we && (rf_waddr != 5'd0)) regs_q[rf_waddr] <= rf_wdata;
    end
  end

  // Bus outputs are gated by rst so a reset mid-transfer drops the request immediately.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      case (state_q)
        StFetch: begin
          mem_req  = 1'b1;
          mem_addr = pc_q;
        end
        StMem: begin
          mem_req   = 1'b1;
          mem_addr  = alu_q[ADDR_W-1:0];
          mem_we    = is_sw;
          mem_wdata = is_sw ? b_q : '0;
        end
        default: ;
      endcase
    end
  end

  assign regout = regs_q[dbg_sel][REGOUT_W-1:0];
  assign retire = retire_q;
  assign halted = (state_q == StHalt);

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench for mips_multicycle: a unified memory model with configurable wait states drives
// the bus; register, bus and retire timing are checked against hand-computed values.
module tb_mips_multicycle;

  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_req, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [4:0]    dbg_sel;
  logic [11:0]   regout;
  logic          retire, halted;

  mips_multicycle #(
    .ADDR_W   (AW),
    .RESET_PC (32'h40),
    .REGOUT_W (12)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .dbg_sel   (dbg_sel),
    .regout    (regout),
    .retire    (retire),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  logic [31:0]   mem [256];
  int unsigned   waits, wcnt;
  int            n_checks = 0, n_fail = 0, cyc = 0, viol = 0;
  int            ret_cyc [$];
  int            hs_cyc  [$];
  logic [AW-1:0] hs_addr [$];
  logic          hs_we   [$];
  logic          p_pend;
  logic [AW-1:0] p_addr;
  logic          p_we;
  logic [31:0]   p_wdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  // One clock of simulation: sample at the falling edge, then answer the bus for the next edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (retire) ret_cyc.push_back(cyc);
    if (p_pend && mem_req && (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata))
      viol++;
    if (!mem_req) begin
      mem_ready = 1'b0;
      wcnt      = 0;
    end else begin
      if (mem_ready) wcnt = 0;
      if (wcnt == waits) begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr[9:2]];
        if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
        hs_addr.push_back(mem_addr);
        hs_we.push_back(mem_we);
        hs_cyc.push_back(cyc);
      end else begin
        mem_ready = 1'b0;
        wcnt++;
      end
    end
    p_pend  = mem_req && !mem_ready;
    p_addr  = mem_addr;
    p_we    = mem_we;
    p_wdata = mem_wdata;
  endtask

  task automatic start(input int unsigned w);
    rst       = 1'b1;
    waits     = w;
    mem_ready = 1'b0;
    mem_rdata = '0;
    wcnt      = 0;
    p_pend    = 1'b0;
    ret_cyc.delete();
    hs_cyc.delete();
    hs_addr.delete();
    hs_we.delete();
    step();
    step();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  task automatic check_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
    dbg_sel = r;
    #1;
    check_eq(tag, 32'(regout), exp);
  endtask

  initial begin
    int idx;
    int n;
    dbg_sel   = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;

    // Phase 1: ALU ops, BEQ skip and BNE self-loop with a zero-wait memory.
    clear_mem();
    mem[16] = i_type(6'h23, 0, 1, 16'h0100);
    mem[17] = i_type(6'h23, 0, 2, 16'h0104);
    mem[18] = r_type(1, 2, 3, 0, 6'h20);
    mem[19] = r_type(1, 2, 5, 0, 6'h22);
    mem[20] = r_type(1, 2, 6, 0, 6'h24);
    mem[21] = r_type(1, 2, 7, 0, 6'h25);
    mem[22] = r_type(0, 2, 8, 4, 6'h00);
    mem[23] = r_type(0, 2, 9, 1, 6'h02);
    mem[24] = r_type(1, 2, 0, 0, 6'h20);
    mem[25] = i_type(6'h04, 1, 1, 16'd2);
    mem[26] = 32'hfc00_0000;
    mem[27] = 32'hfc00_0000;
    mem[28] = i_type(6'h05, 1, 0, 16'hffff);
    mem[64] = 32'd5;
    mem[65] = 32'd7;
    start(0);
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_retire", 32'(retire), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    for (int r = 0; r < 32; r++) check_reg($sformatf("rst_reg%0d", r), 5'(r), 32'd0);
    rst = 1'b0;
    step();
    check_eq("first_req", 32'(mem_req), 32'd1);
    check_eq("first_addr", 32'(mem_addr), 32'h40);
    repeat (80) step();
    check_reg("lw_r1", 1, 32'd5);
    check_reg("lw_r2", 2, 32'd7);
    check_reg("add_r3", 3, 32'd12);
    check_reg("sub_r5", 5, 32'hffe);
    check_reg("and_r6", 6, 32'd5);
    check_reg("or_r7", 7, 32'd7);
    check_reg("sll_r8", 8, 32'h70);
    check_reg("srl_r9", 9, 32'd3);
    check_reg("r0_write_ignored", 0, 32'd0);
    check_eq("no_halt_p1", 32'(halted), 32'd0);
    idx = -1;
    foreach (hs_addr[i]) if (idx < 0 && hs_addr[i] == 16'h48 && !hs_we[i]) idx = i;
    check_eq("add_fetch_seen", 32'(idx >= 0), 32'd1);
    if (idx >= 0 && ret_cyc.size() > 2) check_eq("add_retire_lat", 32'(ret_cyc[2] - hs_cyc[idx]), 32'd4);
    idx = -1;
    foreach (hs_addr[i]) if (idx < 0 && hs_addr[i] == 16'h64) idx = i;
    check_eq("beq_fetch_seen", 32'(idx >= 0 && idx + 1 < hs_addr.size()), 32'd1);
    if (idx >= 0 && idx + 1 < hs_addr.size()) check_eq("beq_target", 32'(hs_addr[idx+1]), 32'h70);
    n = hs_addr.size();
    check_eq("bne_loop_hs", 32'(n >= 2), 32'd1);
    if (n >= 2) begin
      check_eq("bne_loop_addr_a", 32'(hs_addr[n-1]), 32'h70);
      check_eq("bne_loop_addr_b", 32'(hs_addr[n-2]), 32'h70);
    end
    n = ret_cyc.size();
    check_eq("bne_retire_seen", 32'(n >= 2), 32'd1);
    if (n >= 2) check_eq("bne_retire_period", 32'(ret_cyc[n-1] - ret_cyc[n-2]), 32'd3);

    // Phase 2: SW then LW with one wait state per access (ready on the second request cycle).
    clear_mem();
    mem[16] = i_type(6'h23, 0, 1, 16'h0100);
    mem[17] = i_type(6'h2b, 0, 1, 16'd8);
    mem[18] = i_type(6'h23, 0, 4, 16'd8);
    mem[19] = i_type(6'h05, 1, 0, 16'hffff);
    mem[64] = 32'd5;
    start(1);
    rst = 1'b0;
    repeat (60) step();
    check_eq("sw_mem_word8", mem[2], 32'd5);
    check_reg("lw_r4", 4, 32'd5);
    check_eq("bus_stable_viol", 32'(viol), 32'd0);
    idx = -1;
    foreach (hs_we[i]) if (idx < 0 && hs_we[i]) idx = i;
    check_eq("sw_hs_seen", 32'(idx >= 0), 32'd1);
    if (idx >= 0) check_eq("sw_hs_addr", 32'(hs_addr[idx]), 32'd8);
    check_eq("p2_retires", 32'(ret_cyc.size() >= 3), 32'd1);
    if (ret_cyc.size() >= 3) begin
      check_eq("sw_cycles_1wait", 32'(ret_cyc[1] - ret_cyc[0]), 32'd6);
      check_eq("lw_cycles_1wait", 32'(ret_cyc[2] - ret_cyc[1]), 32'd7);
    end
    // Async reset while a request is stalled must drop mem_req without waiting for a clock.
    idx = 0;
    for (int i = 0; i < 10 && idx == 0; i++) begin
      step();
      if (mem_req && !mem_ready) idx = 1;
    end
    check_eq("abort_wait_found", 32'(idx), 32'd1);
    #2 rst = 1'b1;
    #1 check_eq("abort_req_drop", 32'(mem_req), 32'd0);

    // Phase 3: illegal opcode halts; reset recovers; illegal funct also halts.
    clear_mem();
    mem[16] = 32'hfc00_0000;
    start(0);
    rst = 1'b0;
    repeat (4) step();
    check_eq("halt_opcode", 32'(halted), 32'd1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mem_req) n++;
    end
    check_eq("halt_no_req", 32'(n), 32'd0);
    start(0);
    rst = 1'b0;
    step();
    check_eq("recover_req", 32'(mem_req), 32'd1);
    check_eq("recover_addr", 32'(mem_addr), 32'h40);
    check_eq("recover_halted", 32'(halted), 32'd0);
    mem[16] = r_type(1, 2, 3, 0, 6'h3f);
    start(0);
    rst = 1'b0;
    repeat (4) step();
    check_eq("halt_funct", 32'(halted), 32'd1);

    // Phase 4: J with target field 0x10 -> 0x40 (itself), or a halt when J is not built in.
    clear_mem();
    mem[16] = {6'h02, 26'h10};
    start(0);
    rst = 1'b0;
    repeat (12) step();
`ifdef MIPS_MC_JUMP_EN
    check_eq("j_no_halt", 32'(halted), 32'd0);
    check_eq("j_hs_count", 32'(hs_addr.size() >= 2), 32'd1);
    if (hs_addr.size() >= 2) check_eq("j_target", 32'(hs_addr[1]), 32'h40);
    n = ret_cyc.size();
    check_eq("j_retires", 32'(n >= 2), 32'd1);
    if (n >= 2) check_eq("j_period", 32'(ret_cyc[n-1] - ret_cyc[n-2]), 32'd3);
`else
    check_eq("j_disabled_halt", 32'(halted), 32'd1);
    check_eq("j_disabled_req", 32'(mem_req), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
